legv8_seq_ctrl: RTL and testbench
=================================

# legv8_seq_ctrl

Multicycle sequencer for the LEGv8 datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath control buses. It runs the request/acknowledge handshakes to instruction and data memory, with a watchdog on each. It sits between the IR/PC registers and the existing datapath mux, ALU, register-file and memory enables, and replaces single-cycle control.

## Interface
- `ACK_TIMEOUT`, 15: maximum wait cycles for an ack before bus error (1..255).
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; the only reset.
- `opcode` in 11: IR[31:21]; valid from DECODE onward.
- `zero` in 1: ALU zero flag, sampled in EXEC.
- `imem_ack` in 1: instruction memory has data; instruction sits on the IR input.
- `dmem_ack` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `ir_we` out 1: load IR.
- `pc_we` out 1: update PC.
- `pc_src` out 1: 0 = PC+4, 1 = branch target.
- `reg2loc` out 1: register read-port-2 select.
- `seu` out 2: sign-extend mode.
- `alu_src` out 1: 1 = immediate operand.
- `alu_op` out 3: ALU operation.
- `dmem_rd` out 1: data memory read.
- `dmem_wr` out 1: data memory write.
- `mem_to_reg` out 1: writeback source, 1 = memory.
- `reg_we` out 1: register file write enable.
- `illegal` out 1: one-cycle pulse on an undecodable opcode.
- `bus_err` out 1: sticky memory-timeout flag.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- `instr_count` out CNT_W: retired-instruction count.

## Operation
**Decode.** DECODE latches an instruction class register from `opcode`; the class is held until the next DECODE. Classes and encodings:
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- LDUR 11111000010, STUR 11111000000.
- B 000101xxxxx.
- CBZ 10110100xxx, CBNZ 10110101xxx.
- ADDI 1001000100x, SUBI 1101000100x, ANDI 1001001000x, ORRI 1011001000x.

**Control values.** Every output is 0 when not stated below; no X values are ever driven.
- R-type: `alu_op` ADD 000, SUB 001, AND 010, ORR 011; `alu_src`=0, `reg2loc`=0.
- I-type: `alu_op` as for R-type; `seu`=00, `alu_src`=1.
- LDUR/STUR: `seu`=01, `alu_src`=1, `alu_op`=000; STUR also drives `reg2loc`=1.
- CB: `seu`=11, `reg2loc`=1, `alu_op`=100.
- B: `seu`=10.
- The class-dependent control values (`seu`, `alu_src`, `alu_op`, `reg2loc`) are held through EXEC, MEM and WB.

**State machine.**
- **FETCH**
  - `imem_req`=1 until `imem_ack`.
  - On the ack cycle: `ir_we`=1, go to DECODE.
- **DECODE**
  - One cycle; latch the class.
  - Unknown opcode: `illegal`=1, `pc_we`=1, `pc_src`=0, go to FETCH. The instruction is skipped and counted.
  - Otherwise go to EXEC.
- **EXEC**
  - R-type / I-type: go to WB.
  - LDUR / STUR: go to MEM.
  - B: `pc_we`=1, `pc_src`=1, go to FETCH.
  - CBZ: `pc_we`=1, `pc_src`=`zero`, go to FETCH.
  - CBNZ: `pc_we`=1, `pc_src`=!`zero`, go to FETCH.
- **MEM**
  - LDUR holds `dmem_rd`=1; STUR holds `dmem_wr`=1, until `dmem_ack`.
  - On ack, STUR: `pc_we`=1, go to FETCH.
  - On ack, LDUR: go to WB.
- **WB**
  - `reg_we`=1, `mem_to_reg`=1 for LDUR and 0 otherwise.
  - `pc_we`=1, `pc_src`=0, go to FETCH.
- **HALT**
  - All controls 0, `bus_err`=1.
  - Leaves HALT only on `reset`.

**Watchdog.**
- An 8-bit wait counter clears on entry to FETCH or MEM.
- It increments each cycle the ack is absent.
- When the count reaches `ACK_TIMEOUT` with no ack, go to HALT and set `bus_err`.
- An ack arriving in the same cycle as the timeout wins: normal transition, no error.

**Retired-instruction counter.** `instr_count` increments on every cycle with `pc_we`=1 and wraps modulo 2^CNT_W.

## Timing
**Output type.** All control outputs are combinational from the registered state, the class register, `zero` and the acks. Next-state logic and counters update on the rising edge of `clk`.

**Reset.**
- While `reset`=1 every output is forced to 0.
- On the next edge: state=FETCH, class=ILLEGAL, wait counter=0, `instr_count`=0, `bus_err`=0.
- Reset in any state, including mid-MEM and HALT, aborts with no `reg_we` or `pc_we`.

**Handshake rules.**
- A request is held until its ack; the ack is sampled only while the request is high.
- Acks outside FETCH or MEM are ignored.

**Latency.** With ack in the first cycle of the wait:

| Instruction | Cycles |
|---|---|
| R-type / I-type | 4 |
| LDUR | 5 |
| STUR | 4 |
| B / CB | 3 |
| illegal | 2 |

Each wait cycle adds 1.

**Other rules.**
- `pc_we` is never high in two consecutive cycles.
- `ir_we` is high exactly once per instruction.

## Test plan
- **R-type ADD.** Reset, then opcode 10001011000 with `imem_ack` on the first FETCH cycle. Required: states 0,1,2,4,0; `reg_we` only in WB; `alu_op`=000; `instr_count`=1.
- **LDUR.** LDUR with `dmem_ack` delayed 3 cycles. Required: `dmem_rd` high 4 cycles; WB has `mem_to_reg`=1, `reg_we`=1; 8 cycles total.
- **CBZ.** CBZ with `zero`=1, then CBZ with `zero`=0. Required: EXEC shows `pc_we`=1 with `pc_src`=1, then `pc_we`=1 with `pc_src`=0; `reg_we` stays 0.
- **Illegal opcode.** Opcode 00000000000. Required: `illegal` pulses once in DECODE, `pc_we`=1, back to FETCH.
- **Watchdog.** `ACK_TIMEOUT`=4, `imem_ack` held 0. Required: HALT after 4 wait cycles with `bus_err`=1 and all controls 0. Repeat with the ack in the timeout cycle: no error.
- **Reset mid-access and counter wrap.** Assert `reset` mid-MEM of a STUR. Required: `dmem_wr` drops in the reset cycle, no `pc_we`, state=FETCH afterwards. Separately, `CNT_W`=2 with 5 retirements gives `instr_count`=1.

Source files
------------

// File: rtl/legv8_seq_ctrl.sv
// Multicycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB control with memory
// handshakes, per-access watchdog and a retired-instruction counter.
module legv8_seq_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg2loc,
    output logic [1:0]       seu,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             mem_to_reg,
    output logic             reg_we,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        ClsIllegal, ClsAdd, ClsSub, ClsAnd, ClsOrr,
        ClsAddi, ClsSubi, ClsAndi, ClsOrri,
        ClsLdur, ClsStur, ClsB, ClsCbz, ClsCbnz
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, cls_dec;
    logic [7:0]       wait_q, wait_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_hit;
    logic [1:0]       seu_c;
    logic             alu_src_c, reg2loc_c;
    logic [2:0]       alu_op_c;

    always_comb begin
        cls_dec = ClsIllegal;
        casez (opcode)
            11'b10001011000: cls_dec = ClsAdd;
            11'b11001011000: cls_dec = ClsSub;
            11'b10001010000: cls_dec = ClsAnd;
            11'b10101010000: cls_dec = ClsOrr;
            11'b11111000010: cls_dec = ClsLdur;
            11'b11111000000: cls_dec = ClsStur;
            11'b000101?????: cls_dec = ClsB;
            11'b10110100???: cls_dec = ClsCbz;
            11'b10110101???: cls_dec = ClsCbnz;
            11'b1001000100?: cls_dec = ClsAddi;
            11'b1101000100?: cls_dec = ClsSubi;
            11'b1001001000?: cls_dec = ClsAndi;
            11'b1011001000?: cls_dec = ClsOrri;
            default:         cls_dec = ClsIllegal;
        endcase
    end

    always_comb begin
        seu_c     = 2'b00;
        alu_src_c = 1'b0;
        alu_op_c  = 3'b000;
        reg2loc_c = 1'b0;
        case (cls_q)
            ClsSub:  alu_op_c = 3'b001;
            ClsAnd:  alu_op_c = 3'b010;
            ClsOrr:  alu_op_c = 3'b011;
            ClsAddi: alu_src_c = 1'b1;
            ClsSubi: begin alu_src_c = 1'b1; alu_op_c = 3'b001; end
            ClsAndi: begin alu_src_c = 1'b1; alu_op_c = 3'b010; end
            ClsOrri: begin alu_src_c = 1'b1; alu_op_c = 3'b011; end
            ClsLdur: begin seu_c = 2'b01; alu_src_c = 1'b1; end
            ClsStur: begin seu_c = 2'b01; alu_src_c = 1'b1; reg2loc_c = 1'b1; end
            ClsB:    seu_c = 2'b10;
            ClsCbz, ClsCbnz: begin
                seu_c     = 2'b11;
                reg2loc_c = 1'b1;
                alu_op_c  = 3'b100;
            end
            default: ;
        endcase
    end

    // Timeout fires on the cycle whose missing ack would bring the count to ACK_TIMEOUT.
    assign wait_hit = ({1'b0, wait_q} + 9'd1) == 9'(ACK_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        bus_err_d  = bus_err_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        seu        = 2'b00;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        illegal    = 1'b0;

        if (state_q inside {StExec, StMem, StWb}) begin
            seu     = seu_c;
            alu_src = alu_src_c;
            alu_op  = alu_op_c;
            reg2loc = reg2loc_c;
        end

        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (wait_hit) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end
            end
            StDecode: begin
                cls_d = cls_dec;
                if (cls_dec == ClsIllegal) begin
                    illegal = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsLdur, ClsStur: state_d = StMem;
                    ClsB: begin
                        pc_we   = 1'b1;
                        pc_src  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsCbz: begin
                        pc_we   = 1'b1;
                        pc_src  = zero;
                        state_d = StFetch;
                    end
                    ClsCbnz: begin
                        pc_we   = 1'b1;
                        pc_src  = ~zero;
                        state_d = StFetch;
                    end
                    default: state_d = StWb;
                endcase
            end
            StMem: begin
                dmem_rd = (cls_q == ClsLdur);
                dmem_wr = (cls_q != ClsLdur);
                if (dmem_ack) begin
                    if (cls_q == ClsLdur) begin
                        state_d = StWb;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = StFetch;
                    end
                end else if (wait_hit) begin
                    state_d   = StHalt;
                    bus_err_d = 1'b1;
                end
            end
            StWb: begin
                reg_we     = 1'b1;
                mem_to_reg = (cls_q == ClsLdur);
                pc_we      = 1'b1;
                state_d    = StFetch;
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase

        // Staying put in FETCH/MEM means the ack was absent this cycle.
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (state_q == StFetch || state_q == StMem) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end

        cnt_d = pc_we ? cnt_q + CNT_W'(1) : cnt_q;

        state       = state_q;
        bus_err     = bus_err_q;
        instr_count = cnt_q;

        if (reset) begin
            imem_req    = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_src      = 1'b0;
            reg2loc     = 1'b0;
            seu         = 2'b00;
            alu_src     = 1'b0;
            alu_op      = 3'b000;
            dmem_rd     = 1'b0;
            dmem_wr     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_we      = 1'b0;
            illegal     = 1'b0;
            bus_err     = 1'b0;
            state       = 3'd0;
            instr_count = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsIllegal;
            wait_q    <= 8'd0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_legv8_seq_ctrl.sv
// Directed bench for legv8_seq_ctrl: per-cycle expected control vectors for
// each instruction class, watchdog, reset abort and counter wrap.
module tb_legv8_seq_ctrl;

    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpOrri = 11'b10110010001;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [10:0] OpB    = 11'b00010101010;
    localparam logic [10:0] OpCbz  = 11'b10110100011;
    localparam logic [10:0] OpCbnz = 11'b10110101100;
    localparam logic [10:0] OpBad  = 11'b00000000000;

    logic        clk = 1'b0;
    logic        reset, zero, imem_ack, dmem_ack;
    logic [10:0] opcode;

    logic        imem_req, ir_we, pc_we, pc_src, reg2loc, alu_src;
    logic        dmem_rd, dmem_wr, mem_to_reg, reg_we, illegal, bus_err;
    logic [1:0]  seu;
    logic [2:0]  alu_op, state;
    logic [15:0] instr_count;

    logic        w_imem_req, w_ir_we, w_pc_we, w_pc_src, w_reg2loc, w_alu_src;
    logic        w_dmem_rd, w_dmem_wr, w_mem_to_reg, w_reg_we, w_illegal, w_bus_err;
    logic [1:0]  w_seu;
    logic [2:0]  w_alu_op, w_state;
    logic [1:0]  w_instr_count;

    int tests  = 0;
    int failed = 0;

    logic [10:0] op_s [16];
    logic        ia_s [16];
    logic        da_s [16];
    logic        z_s  [16];
    logic [19:0] ev_s [16];

    always #5 clk = ~clk;

    wire [19:0] obs = {imem_req, ir_we, pc_we, pc_src, reg2loc, seu, alu_src, alu_op,
                       dmem_rd, dmem_wr, mem_to_reg, reg_we, illegal, bus_err, state};
    wire [19:0] w_obs = {w_imem_req, w_ir_we, w_pc_we, w_pc_src, w_reg2loc, w_seu, w_alu_src,
                         w_alu_op, w_dmem_rd, w_dmem_wr, w_mem_to_reg, w_reg_we, w_illegal,
                         w_bus_err, w_state};

    legv8_seq_ctrl #(.ACK_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .reg2loc(reg2loc), .seu(seu), .alu_src(alu_src),
        .alu_op(alu_op), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .mem_to_reg(mem_to_reg),
        .reg_we(reg_we), .illegal(illegal), .bus_err(bus_err), .state(state),
        .instr_count(instr_count)
    );

    legv8_seq_ctrl #(.ACK_TIMEOUT(4), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(w_imem_req), .ir_we(w_ir_we),
        .pc_we(w_pc_we), .pc_src(w_pc_src), .reg2loc(w_reg2loc), .seu(w_seu),
        .alu_src(w_alu_src), .alu_op(w_alu_op), .dmem_rd(w_dmem_rd), .dmem_wr(w_dmem_wr),
        .mem_to_reg(w_mem_to_reg), .reg_we(w_reg_we), .illegal(w_illegal),
        .bus_err(w_bus_err), .state(w_state), .instr_count(w_instr_count)
    );

    function automatic logic [19:0] pk(input logic req, irw, pcw, pcs, r2l,
                                       input logic [1:0] seu_v, input logic asrc,
                                       input logic [2:0] aop,
                                       input logic rd, wr, m2r, rwe, ill, berr,
                                       input logic [2:0] st);
        return {req, irw, pcw, pcs, r2l, seu_v, asrc, aop, rd, wr, m2r, rwe, ill, berr, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        zero     = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set(input int c, input logic [10:0] op, input logic ia, da, z,
                       input logic [19:0] ev);
        op_s[c] = op;
        ia_s[c] = ia;
        da_s[c] = da;
        z_s[c]  = z;
        ev_s[c] = ev;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        opcode   = OpAdd;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        zero     = 1'b0;
        tick();
        tick();
        tests++;
        if (obs !== 20'h0) begin
            failed++;
            $display("FAIL reset_outputs: got %h, want %h", obs, 20'h0);
        end
        tests++;
        if (instr_count !== 16'd0) begin
            failed++;
            $display("FAIL reset_count: got %0d, want 0", instr_count);
        end
        reset    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        tests++;
        if (obs !== pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0)) begin
            failed++;
            $display("FAIL reset_release: got %h, want fetch %h", obs,
                     pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        end
    endtask

    task automatic test_rtype_add();
        do_reset();
        set(0, OpAdd, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpAdd, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(2, OpAdd, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd2));
        set(3, OpAdd, 0, 0, 0, pk(0,0,1,0,0,2'b00,0,3'b000,0,0,0,1,0,0,3'd4));
        set(4, OpAdd, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        for (int c = 0; c < 5; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL add cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
        tests++;
        if (instr_count !== 16'd1) begin
            failed++;
            $display("FAIL add_count: got %0d, want 1", instr_count);
        end
    endtask

    task automatic test_itype_sub();
        do_reset();
        set(0, OpOrri, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpOrri, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(2, OpOrri, 0, 0, 0, pk(0,0,0,0,0,2'b00,1,3'b011,0,0,0,0,0,0,3'd2));
        set(3, OpOrri, 0, 0, 0, pk(0,0,1,0,0,2'b00,1,3'b011,0,0,0,1,0,0,3'd4));
        set(4, OpSub,  1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(5, OpSub,  0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(6, OpSub,  0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b001,0,0,0,0,0,0,3'd2));
        set(7, OpSub,  0, 0, 0, pk(0,0,1,0,0,2'b00,0,3'b001,0,0,0,1,0,0,3'd4));
        set(8, OpSub,  0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        for (int c = 0; c < 9; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL orri_sub cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
    endtask

    task automatic test_ldur();
        do_reset();
        set(0, OpLdur, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpLdur, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(2, OpLdur, 0, 0, 0, pk(0,0,0,0,0,2'b01,1,3'b000,0,0,0,0,0,0,3'd2));
        set(3, OpLdur, 0, 0, 0, pk(0,0,0,0,0,2'b01,1,3'b000,1,0,0,0,0,0,3'd3));
        set(4, OpLdur, 0, 0, 0, pk(0,0,0,0,0,2'b01,1,3'b000,1,0,0,0,0,0,3'd3));
        set(5, OpLdur, 0, 0, 0, pk(0,0,0,0,0,2'b01,1,3'b000,1,0,0,0,0,0,3'd3));
        set(6, OpLdur, 0, 1, 0, pk(0,0,0,0,0,2'b01,1,3'b000,1,0,0,0,0,0,3'd3));
        set(7, OpLdur, 0, 0, 0, pk(0,0,1,0,0,2'b01,1,3'b000,0,0,1,1,0,0,3'd4));
        set(8, OpLdur, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        for (int c = 0; c < 9; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL ldur cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
    endtask

    task automatic test_stur();
        do_reset();
        set(0, OpStur, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpStur, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(2, OpStur, 0, 0, 0, pk(0,0,0,0,1,2'b01,1,3'b000,0,0,0,0,0,0,3'd2));
        set(3, OpStur, 0, 1, 0, pk(0,0,1,0,1,2'b01,1,3'b000,0,1,0,0,0,0,3'd3));
        set(4, OpStur, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        for (int c = 0; c < 5; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL stur cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
    endtask

    task automatic test_cbz();
        do_reset();
        set(0, OpCbz, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpCbz, 0, 0, 1, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(2, OpCbz, 0, 0, 1, pk(0,0,1,1,1,2'b11,0,3'b100,0,0,0,0,0,0,3'd2));
        set(3, OpCbz, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(4, OpCbz, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(5, OpCbz, 0, 0, 0, pk(0,0,1,0,1,2'b11,0,3'b100,0,0,0,0,0,0,3'd2));
        set(6, OpCbz, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        for (int c = 0; c < 7; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL cbz cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
    endtask

    task automatic test_b_cbnz();
        do_reset();
        set(0, OpB,    1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpB,    0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(2, OpB,    0, 0, 0, pk(0,0,1,1,0,2'b10,0,3'b000,0,0,0,0,0,0,3'd2));
        set(3, OpCbnz, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(4, OpCbnz, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(5, OpCbnz, 0, 0, 0, pk(0,0,1,1,1,2'b11,0,3'b100,0,0,0,0,0,0,3'd2));
        set(6, OpCbnz, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        for (int c = 0; c < 7; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL b_cbnz cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
        tests++;
        if (instr_count !== 16'd2) begin
            failed++;
            $display("FAIL b_cbnz_count: got %0d, want 2", instr_count);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set(0, OpBad, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpBad, 0, 0, 0, pk(0,0,1,0,0,2'b00,0,3'b000,0,0,0,0,1,0,3'd1));
        set(2, OpBad, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        for (int c = 0; c < 3; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL illegal cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
        tests++;
        if (instr_count !== 16'd1) begin
            failed++;
            $display("FAIL illegal_count: got %0d, want 1", instr_count);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int c = 0; c < 4; c++)
            set(c, OpAdd, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(4, OpAdd, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,1,3'd7));
        set(5, OpAdd, 1, 1, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,1,3'd7));
        for (int c = 0; c < 6; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL timeout cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
        do_reset();
        for (int c = 0; c < 3; c++)
            set(c, OpAdd, 0, 0, 0, pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(3, OpAdd, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(4, OpAdd, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        for (int c = 0; c < 5; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL ack_at_timeout cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        set(0, OpStur, 1, 0, 0, pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        set(1, OpStur, 0, 0, 0, pk(0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd1));
        set(2, OpStur, 0, 0, 0, pk(0,0,0,0,1,2'b01,1,3'b000,0,0,0,0,0,0,3'd2));
        set(3, OpStur, 0, 0, 0, pk(0,0,0,0,1,2'b01,1,3'b000,0,1,0,0,0,0,3'd3));
        for (int c = 0; c < 4; c++) begin
            opcode = op_s[c]; imem_ack = ia_s[c]; dmem_ack = da_s[c]; zero = z_s[c];
            #1;
            tests++;
            if (obs !== ev_s[c]) begin
                failed++;
                $display("FAIL mid_mem cycle %0d: got %h, want %h", c, obs, ev_s[c]);
            end
            tick();
        end
        reset    = 1'b1;
        dmem_ack = 1'b1;
        #1;
        tests++;
        if (obs !== 20'h0) begin
            failed++;
            $display("FAIL mid_mem_reset_cycle: got %h, want %h", obs, 20'h0);
        end
        tick();
        reset    = 1'b0;
        dmem_ack = 1'b0;
        #1;
        tests++;
        if (obs !== pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0) || instr_count !== 16'd0) begin
            failed++;
            $display("FAIL mid_mem_after: got %h cnt %0d, want %h cnt 0", obs, instr_count,
                     pk(1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        opcode   = OpBad;
        imem_ack = 1'b1;
        // Each illegal instruction retires in two cycles.
        repeat (10) tick();
        tests++;
        if (w_instr_count !== 2'd1) begin
            failed++;
            $display("FAIL wrap_count: got %0d, want 1", w_instr_count);
        end
        tests++;
        if (instr_count !== 16'd5) begin
            failed++;
            $display("FAIL wide_count: got %0d, want 5", instr_count);
        end
        tests++;
        if (w_obs !== pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0)) begin
            failed++;
            $display("FAIL wrap_fetch: got %h, want %h", w_obs,
                     pk(1,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0,0,3'd0));
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 11'd0;
        zero     = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        test_reset();
        test_rtype_add();
        test_itype_sub();
        test_ldur();
        test_stur();
        test_cbz();
        test_b_cbnz();
        test_illegal();
        test_watchdog();
        test_reset_mid_mem();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
